// File: rtl/traffic_ctrl_timed.sv
// Timed two-road traffic light controller with EW demand/gap-out, pedestrian walk and night flash.
// Latency: lamp outputs are registered and change on the same edge that changes state.
// Backpressure: none; inputs are sampled every cycle, timing advances only on tick.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   tick        one-cycle time-base strobe; every duration counts ticks
//   ped_req     pedestrian button (level or pulse)
//   ew_car      EW vehicle detector (level)
//   flash_mode  night flash request (level)
//   ns, ew      lamp codes: 00 red, 01 green, 10 yellow, 11 dark
//   walk        pedestrian walk lamp
//   ped_pending latched pedestrian request awaiting service
//   phase       current state code
module traffic_ctrl_timed #(
    parameter int CNT_W       = 8,
    parameter int T_NS_GREEN  = 30,
    parameter int T_EW_GREEN  = 20,
    parameter int T_MIN_GREEN = 8,
    parameter int T_YELLOW    = 4,
    parameter int T_ALLRED    = 2,
    parameter int T_WALK      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       ew_car,
    input  logic       flash_mode,
    output logic [1:0] ns,
    output logic [1:0] ew,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ALLRED_NS = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_EW = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6,
        FLASH     = 3'd7
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;
    localparam logic [1:0] LAMP_DARK   = 2'b11;

    // Expiry thresholds: a phase of T ticks ends on the tick seen with elapsed == T-1.
    localparam logic [CNT_W-1:0] L_NS_GREEN  = CNT_W'(T_NS_GREEN - 1);
    localparam logic [CNT_W-1:0] L_EW_GREEN  = CNT_W'(T_EW_GREEN - 1);
    localparam logic [CNT_W-1:0] L_MIN_GREEN = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] L_YELLOW    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] L_ALLRED    = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] L_WALK      = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] elapsed;
    logic             flash_ph;
    logic             flash_ph_nxt;
    logic             ped_nxt;
    logic [1:0]       ns_nxt;
    logic [1:0]       ew_nxt;
    logic             walk_nxt;

    logic exp_ns_green;
    logic exp_min_green;
    logic exp_yellow;
    logic exp_allred;
    logic exp_walk;
    logic ew_max_out;

    always_comb begin
        exp_ns_green  = tick && (elapsed >= L_NS_GREEN);
        exp_min_green = tick && (elapsed >= L_MIN_GREEN);
        exp_yellow    = tick && (elapsed >= L_YELLOW);
        exp_allred    = tick && (elapsed >= L_ALLRED);
        exp_walk      = tick && (elapsed >= L_WALK);
        ew_max_out    = tick && (elapsed == L_EW_GREEN);
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        flash_ph_nxt = flash_ph;
        case (state)
            ALLRED_NS: begin
                if (exp_allred) begin
                    if (flash_mode)       state_nxt = FLASH;
                    else if (ped_pending) state_nxt = PED_WALK;
                    else                  state_nxt = NS_GREEN;
                end
            end
            NS_GREEN: begin
                // Rests in green until the minimum has run and someone is waiting.
                if (exp_ns_green && (ew_car || ped_pending)) state_nxt = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (exp_yellow) state_nxt = ALLRED_EW;
            end
            ALLRED_EW: begin
                if (exp_allred) state_nxt = EW_GREEN;
            end
            EW_GREEN: begin
                if (ew_max_out || (exp_min_green && !ew_car)) state_nxt = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (exp_yellow) state_nxt = ALLRED_NS;
            end
            PED_WALK: begin
                if (exp_walk) state_nxt = NS_GREEN;
            end
            FLASH: begin
                if (tick) begin
                    if (!flash_mode) begin
                        state_nxt    = ALLRED_NS;
                        flash_ph_nxt = 1'b0;
                    end else begin
                        flash_ph_nxt = ~flash_ph;
                    end
                end
            end
            default: state_nxt = ALLRED_NS;
        endcase
    end

    // Pedestrian latch: entering the walk phase clears it, and that clear
    // beats a button press in the same cycle. Presses during the walk are ignored.
    always_comb begin
        ped_nxt = ped_pending;
        if ((state_nxt == PED_WALK) && (state != PED_WALK)) ped_nxt = 1'b0;
        else if (ped_req && (state != PED_WALK))            ped_nxt = 1'b1;
    end

    // Lamp decode from the next state so the registered lamps track the state register.
    always_comb begin
        ns_nxt   = LAMP_RED;
        ew_nxt   = LAMP_RED;
        walk_nxt = 1'b0;
        case (state_nxt)
            NS_GREEN:  ns_nxt   = LAMP_GREEN;
            NS_YELLOW: ns_nxt   = LAMP_YELLOW;
            EW_GREEN:  ew_nxt   = LAMP_GREEN;
            EW_YELLOW: ew_nxt   = LAMP_YELLOW;
            PED_WALK:  walk_nxt = 1'b1;
            FLASH: begin
                ns_nxt = flash_ph_nxt ? LAMP_YELLOW : LAMP_DARK;
                ew_nxt = flash_ph_nxt ? LAMP_RED    : LAMP_DARK;
            end
            default: begin
                ns_nxt = LAMP_RED;
                ew_nxt = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ALLRED_NS;
            elapsed     <= '0;
            flash_ph    <= 1'b0;
            ped_pending <= 1'b0;
            ns          <= LAMP_RED;
            ew          <= LAMP_RED;
            walk        <= 1'b0;
            phase       <= 3'd0;
        end else begin
            state       <= state_nxt;
            flash_ph    <= flash_ph_nxt;
            ped_pending <= ped_nxt;
            ns          <= ns_nxt;
            ew          <= ew_nxt;
            walk        <= walk_nxt;
            phase       <= state_nxt;
            if (state_nxt != state)              elapsed <= '0;
            else if (tick && elapsed != CNT_MAX) elapsed <= elapsed + 1'b1;
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_timed.sv
module tb_traffic_ctrl_timed;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       ew_car = 1'b0;
    logic       flash_mode = 1'b0;
    logic [1:0] ns;
    logic [1:0] ew;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;

    traffic_ctrl_timed #(
        .CNT_W(4), .T_NS_GREEN(3), .T_EW_GREEN(4), .T_MIN_GREEN(2),
        .T_YELLOW(2), .T_ALLRED(1), .T_WALK(2)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .ew_car(ew_car),
        .flash_mode(flash_mode), .ns(ns), .ew(ew), .walk(walk),
        .ped_pending(ped_pending), .phase(phase)
    );

    always #5 clk = ~clk;

    // One record: inputs held for one cycle, expected outputs after the following edge.
    typedef struct {
        logic       r;
        logic       t;
        logic       p;
        logic       c;
        logic       f;
        logic [2:0] ph;
        logic       pend;
        logic       fph;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic t, input logic p, input logic c,
                       input logic f, input logic [2:0] ph, input logic pend, input logic fph);
        vec_t v;
        v.r = r; v.t = t; v.p = p; v.c = c; v.f = f;
        v.ph = ph; v.pend = pend; v.fph = fph;
        vecs.push_back(v);
    endtask

    // Normal running vectors: out of reset, tick every cycle, no button.
    task automatic run(input logic c, input logic f, input logic [2:0] ph, input logic pend);
        add(1'b1, 1'b1, 1'b0, c, f, ph, pend, 1'b0);
    endtask

    // Lamp table: {ns, ew, walk}
    function automatic logic [4:0] lamps(input logic [2:0] ph, input logic fph);
        case (ph)
            3'd1:    return 5'b01_00_0;
            3'd2:    return 5'b10_00_0;
            3'd4:    return 5'b00_01_0;
            3'd5:    return 5'b00_10_0;
            3'd6:    return 5'b00_00_1;
            3'd7:    return fph ? 5'b10_00_0 : 5'b11_11_0;
            default: return 5'b00_00_0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [4:0] l;
        logic       both_lit;
        rst = v.r; tick = v.t; ped_req = v.p; ew_car = v.c; flash_mode = v.f;
        @(posedge clk);
        #1;
        l = lamps(v.ph, v.fph);
        both_lit = (ns == 2'b01 || ns == 2'b10) && (ew == 2'b01 || ew == 2'b10);
        chk({tag, " phase"}, {1'b0, phase}, {1'b0, v.ph});
        chk({tag, " ns"}, {2'b0, ns}, {2'b0, l[4:3]});
        chk({tag, " ew"}, {2'b0, ew}, {2'b0, l[2:1]});
        chk({tag, " walk"}, {3'b0, walk}, {3'b0, l[0]});
        chk({tag, " ped_pending"}, {3'b0, ped_pending}, {3'b0, v.pend});
        chk({tag, " conflict"}, {3'b0, both_lit}, 4'd0);
    endtask

    task automatic run_n(input logic c, input logic f, input logic [2:0] ph,
                         input logic pend, input int n);
        for (int i = 0; i < n; i++) run(c, f, ph, pend);
    endtask

    initial begin
        vec_t v;

        // 1: reset then full cycle with EW demand: 0,1,1,1,2,2,3,4,4,4,4,5,5,0,1
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        run_n(1, 0, 3'd1, 0, 3);
        run_n(1, 0, 3'd2, 0, 2);
        run_n(1, 0, 3'd3, 0, 1);
        run_n(1, 0, 3'd4, 0, 4);
        run_n(1, 0, 3'd5, 0, 2);
        run_n(1, 0, 3'd0, 0, 1);
        run_n(1, 0, 3'd1, 0, 1);

        // 2: no demand rests in NS green (elapsed saturates), then demand ends it
        run_n(0, 0, 3'd1, 0, 50);
        run_n(1, 0, 3'd2, 0, 1);

        // 3a: gap-out after the 2-tick minimum
        run_n(1, 0, 3'd2, 0, 1);
        run_n(1, 0, 3'd3, 0, 1);
        run_n(1, 0, 3'd4, 0, 2);
        run_n(0, 0, 3'd5, 0, 2);
        run_n(0, 0, 3'd0, 0, 1);
        run_n(0, 0, 3'd1, 0, 1);
        // 3b: held demand maxes out after 4 ticks
        run_n(1, 0, 3'd1, 0, 2);
        run_n(1, 0, 3'd2, 0, 2);
        run_n(1, 0, 3'd3, 0, 1);
        run_n(1, 0, 3'd4, 0, 4);
        run_n(1, 0, 3'd5, 0, 2);
        run_n(1, 0, 3'd0, 0, 1);
        run_n(1, 0, 3'd1, 0, 1);

        // 4: pedestrian pulse in NS green, served after the EW cycle
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
        run_n(0, 0, 3'd1, 1, 1);
        run_n(0, 0, 3'd2, 1, 2);
        run_n(0, 0, 3'd3, 1, 1);
        run_n(0, 0, 3'd4, 1, 2);
        run_n(0, 0, 3'd5, 1, 2);
        run_n(0, 0, 3'd0, 1, 1);
        run_n(0, 0, 3'd6, 0, 1);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0);   // press ignored during walk
        run_n(0, 0, 3'd1, 0, 1);

        // 5: flash requested mid EW green; cycle completes, then flash alternates
        run_n(1, 0, 3'd1, 0, 2);
        run_n(1, 0, 3'd2, 0, 2);
        run_n(1, 0, 3'd3, 0, 1);
        run_n(1, 0, 3'd4, 0, 1);
        run_n(1, 1, 3'd4, 0, 3);
        run_n(1, 1, 3'd5, 0, 2);
        run_n(1, 1, 3'd0, 0, 1);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);   // press latched, not served
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1);
        run_n(1, 0, 3'd0, 1, 1);
        run_n(1, 0, 3'd6, 0, 2);
        run_n(1, 0, 3'd1, 0, 1);

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // 6: tick every third cycle stretches each phase by 3, then reset mid yellow
        for (int k = 0; k < 9; k++) begin
            v.r = 1'b1; v.t = (k % 3 == 2); v.p = 1'b0; v.c = 1'b1; v.f = 1'b0;
            v.ph = (k == 8) ? 3'd2 : 3'd1; v.pend = 1'b0; v.fph = 1'b0;
            apply(v, $sformatf("slow_ns%0d", k));
        end
        for (int k = 0; k < 5; k++) begin
            v.r = 1'b1; v.t = (k % 3 == 2); v.p = (k == 0); v.c = 1'b1; v.f = 1'b0;
            v.ph = 3'd2; v.pend = 1'b1; v.fph = 1'b0;
            apply(v, $sformatf("slow_yel%0d", k));
        end
        v.r = 1'b0; v.t = 1'b0; v.p = 1'b0; v.c = 1'b1; v.f = 1'b0;
        v.ph = 3'd0; v.pend = 1'b0; v.fph = 1'b0;
        apply(v, "mid_reset");
        v.r = 1'b1; v.t = 1'b0;
        apply(v, "post_reset_hold");
        v.t = 1'b1; v.ph = 3'd1;
        apply(v, "post_reset_tick");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_timed.md
Name: traffic_ctrl_timed

Overview:
Timed two-road traffic light controller (Moore). It sequences NS/EW green, yellow and all-red phases, with parametrised durations counted in time-base ticks. It adds EW vehicle demand with gap-out, a pedestrian all-red walk phase, and a night flash mode. It sits below the intersection top level and drives lamp decoders directly.

Parameters:
CNT_W, 8, width of phase elapsed counter (ticks)
T_NS_GREEN, 30, minimum NS green duration, ticks
T_EW_GREEN, 20, maximum EW green duration, ticks
T_MIN_GREEN, 8, minimum EW green before gap-out, ticks
T_YELLOW, 4, yellow duration (both roads), ticks
T_ALLRED, 2, all-red clearance duration, ticks
T_WALK, 10, pedestrian walk duration, ticks
Legal range for all T_*: 1 to 2^CNT_W-1. Additionally T_MIN_GREEN <= T_EW_GREEN.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
tick  in  1  one-cycle time-base strobe; all timing counts ticks
ped_req  in  1  pedestrian button, level or pulse, sampled every cycle
ew_car  in  1  EW vehicle detector, level
flash_mode  in  1  night flash request, level
ns  out  2  NS lamp: 00=red, 01=green, 10=yellow, 11=dark
ew  out  2  EW lamp, same encoding
walk  out  1  pedestrian walk lamp
ped_pending  out  1  latched pedestrian request awaiting service
phase  out  3  current state code (debug/status)

Behaviour:
- Single clock. rst is synchronous, active-low; sampled only on rising clk. Reset mid-phase takes effect at the next edge.
- Reset values: state=ALLRED_NS, elapsed=0, ped_pending=0, flash_ph=0, ns=00, ew=00, walk=0, phase=0.
- States and phase codes, with outputs as ns/ew/walk:
  - 0 ALLRED_NS: 00/00/0
  - 1 NS_GREEN: 01/00/0
  - 2 NS_YELLOW: 10/00/0
  - 3 ALLRED_EW: 00/00/0
  - 4 EW_GREEN: 00/01/0
  - 5 EW_YELLOW: 00/10/0
  - 6 PED_WALK: 00/00/1
  - 7 FLASH: ns=10 if flash_ph else 11; ew=00 if flash_ph else 11; walk=0
- Outputs are a pure function of the registered state (and flash_ph). They change on the edge that changes state.
- elapsed: cleared on every state change. Otherwise +1 on tick, saturating at 2^CNT_W-1. Holds when tick=0.
- Let "exp(T)" mean tick=1 and elapsed >= T-1. A timed phase of T therefore spans exactly T ticks. All transitions happen on a tick cycle.
- Transitions:
  - ALLRED_NS, exp(T_ALLRED):
    - flash_mode=1 -> FLASH
    - else ped_pending=1 -> PED_WALK
    - else -> NS_GREEN
  - NS_GREEN: exp(T_NS_GREEN) and (ew_car or ped_pending) -> NS_YELLOW. Otherwise rests in green indefinitely, with elapsed saturating.
  - NS_YELLOW, exp(T_YELLOW) -> ALLRED_EW.
  - ALLRED_EW, exp(T_ALLRED) -> EW_GREEN.
  - EW_GREEN -> EW_YELLOW when either:
    - tick and elapsed == T_EW_GREEN-1 (max-out), or
    - exp(T_MIN_GREEN) and ew_car=0 (gap-out).
  - EW_YELLOW, exp(T_YELLOW) -> ALLRED_NS.
  - PED_WALK, exp(T_WALK) -> NS_GREEN.
  - FLASH: on each tick flash_ph toggles. On a tick with flash_mode=0 -> ALLRED_NS and flash_ph cleared.
- flash_mode is examined only at ALLRED_NS expiry and in FLASH. A running cycle always completes to all-red first.
- ped_pending:
  - Set on any cycle with ped_req=1, except while in PED_WALK.
  - Cleared on the edge entering PED_WALK; clear wins over a simultaneous set.
  - Held through FLASH and not served there.
- Never two non-red, non-dark lamps at once. ns and ew are never both 01/10 in any state.

Test Plan (bench params: T_NS_GREEN=3, T_EW_GREEN=4, T_MIN_GREEN=2, T_YELLOW=2, T_ALLRED=1, T_WALK=2, CNT_W=4, tick=1 every cycle):
1. Reset, then ew_car=1 constant, no ped -> phase sequence per cycle: 0,1,1,1,2,2,3,4,4,4,4,5,5,0,1... Outputs match the table; ns/ew never both non-red.
2. ew_car=0, no ped -> phase stays 1 (ns=01) for 50 cycles. Raise ew_car at cycle 50 -> phase=2 on next edge.
3. ew_car=1 entering EW_GREEN, drop to 0 after 1 cycle -> EW_GREEN lasts 2 cycles (gap-out). Held at 1 -> lasts 4 (max-out).
4. ped_req pulse during NS_GREEN with ew_car=0 -> ped_pending=1, NS_YELLOW follows. Later ALLRED_NS -> PED_WALK for 2 cycles with walk=1, ped_pending cleared on entry, then NS_GREEN.
5. flash_mode=1 mid EW_GREEN -> cycle completes to ALLRED_NS, then FLASH. ns alternates 11/10 and ew 11/00 each cycle. flash_mode=0 -> ALLRED_NS then NS_GREEN.
6. tick asserted every 3rd cycle -> each phase duration scales by 3. rst=0 mid NS_YELLOW -> next edge phase=0, all outputs at reset values, ped_pending=0.
